// File: rtl/fifo_pkg.sv
// Shared types and constants for the fifo block and its serial read-side companion.
package fifo_pkg;

    localparam int FIFO_DEPTH_DEFAULT = 4;
    localparam int FIFO_WIDTH_DEFAULT = 2;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } reader_state_t;

    // Bits needed to hold an occupancy in the range 0..depth.
    function automatic int count_width(input int depth);
        return (depth < 1) ? 1 : $clog2(depth + 1);
    endfunction

    // Bits needed for a bit index 0..width-1; at least one bit.
    function automatic int index_width(input int width);
        return (width <= 1) ? 1 : $clog2(width);
    endfunction

endpackage

// File: rtl/fifo_occupancy.sv
// Mirrored FIFO occupancy counter built by snooping the writer's push and the reader's pop.
// Optional FIFO_READER_CHECK_EN adds a sticky flag for count/full disagreement.
module fifo_occupancy
    import fifo_pkg::*;
#(
    parameter int DEPTH = FIFO_DEPTH_DEFAULT,
    parameter int CW    = count_width(DEPTH)
) (
    input  logic          i_clk,
    input  logic          i_reset,
    input  logic          i_push,
    input  logic          i_full,
    input  logic          i_pop,
`ifdef FIFO_READER_CHECK_EN
    output logic          o_sync_err,
`endif
    output logic [CW-1:0] o_count,
    output logic          o_empty
);

    logic [CW-1:0] r_count;
    logic          w_push_eff;

    // A push into a full FIFO only lands when a pop frees the head slot the same cycle.
    assign w_push_eff = i_push & (~i_full | i_pop);

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_count <= '0;
        end else if (w_push_eff && !i_pop) begin
            r_count <= r_count + CW'(1);
        end else if (i_pop && !w_push_eff) begin
            r_count <= r_count - CW'(1);
        end
    end

    assign o_count = r_count;
    assign o_empty = (r_count == '0);

`ifdef FIFO_READER_CHECK_EN
    logic r_sync_err;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_sync_err <= 1'b0;
        end else if ((r_count == CW'(DEPTH)) != i_full) begin
            r_sync_err <= 1'b1;
        end
    end

    assign o_sync_err = r_sync_err;
`endif

endmodule

// File: rtl/fifo_serial_reader.sv
// Drains a fifo and emits each word MSB first on a 1-bit valid/ready stream.
// Optional FIFO_READER_CHECK_EN exposes o_sync_err from the occupancy mirror.
module fifo_serial_reader
    import fifo_pkg::*;
#(
    parameter int DEPTH = FIFO_DEPTH_DEFAULT,
    parameter int WIDTH = FIFO_WIDTH_DEFAULT,
    parameter int CW    = count_width(DEPTH)
) (
    input  logic          i_clk,
    input  logic          i_reset,
    input  logic          i_push,
    input  logic          i_full,
    input  logic [WIDTH-1:0] i_fifo_out,
    output logic          o_pop,
    output logic          o_ser_out,
    output logic          o_ser_valid,
    input  logic          i_ser_ready,
    output logic [CW-1:0] o_count,
    output logic          o_empty,
`ifdef FIFO_READER_CHECK_EN
    output logic          o_sync_err,
`endif
    output reader_state_t o_dbg_state
);

    // Serial handshake: a bit moves when o_ser_valid and i_ser_ready are both high at a
    // rising edge; while valid is high and ready is low, o_ser_out and o_ser_valid hold.

    localparam int IW = index_width(WIDTH);
    localparam logic [IW-1:0] LAST_IDX = IW'(WIDTH - 1);

    reader_state_t    r_state;
    reader_state_t    w_next_state;
    logic [WIDTH-1:0] r_shreg;
    logic [IW-1:0]    r_bit_idx;
    logic             w_pop;
    logic             w_ser_valid;
    logic             w_accept;
    logic             w_empty;

    fifo_occupancy #(
        .DEPTH (DEPTH),
        .CW    (CW)
    ) u_occupancy (
        .i_clk      (i_clk),
        .i_reset    (i_reset),
        .i_push     (i_push),
        .i_full     (i_full),
        .i_pop      (w_pop),
`ifdef FIFO_READER_CHECK_EN
        .o_sync_err (o_sync_err),
`endif
        .o_count    (o_count),
        .o_empty    (w_empty)
    );

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_pop        = 1'b0;
        w_ser_valid  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_pop = ~w_empty;
                if (w_pop) begin
                    w_next_state = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                w_ser_valid = 1'b1;
                if (i_ser_ready && (r_bit_idx == LAST_IDX)) begin
                    w_next_state = ST_IDLE;
                end
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    assign w_accept = w_ser_valid & i_ser_ready;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_shreg   <= '0;
            r_bit_idx <= '0;
        end else if (w_pop) begin
            r_shreg   <= i_fifo_out;
            r_bit_idx <= '0;
        end else if (w_accept) begin
            r_shreg   <= r_shreg << 1;
            r_bit_idx <= r_bit_idx + IW'(1);
        end
    end

    assign o_pop       = w_pop;
    assign o_ser_valid = w_ser_valid;
    assign o_ser_out   = r_shreg[WIDTH-1];
    assign o_empty     = w_empty;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_fifo_serial_reader.sv
// Directed bench for fifo_serial_reader attached to a behavioural 4x2 fifo.
module tb_fifo_serial_reader;
    import fifo_pkg::*;

    localparam int DEPTH = 4;
    localparam int WIDTH = 2;

    logic          clk = 1'b0;
    logic          reset;
    logic          push;
    logic [1:0]    din;
    logic          pop;
    logic          ser_out;
    logic          ser_valid;
    logic          ser_ready;
    logic [2:0]    count;
    logic          empty;
    reader_state_t dbg_state;
`ifdef FIFO_READER_CHECK_EN
    logic          sync_err;
`endif

    int n_assert = 0;
    int n_fail   = 0;
    logic [0:0] exp_q[$];

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- attached fifo ----------------
    logic [1:0] mem [0:3];
    logic [1:0] wr_ptr, rd_ptr;
    logic [2:0] m_cnt;
    logic       m_full, m_accept, m_pop;
    logic [1:0] fifo_out;

    assign m_full   = (m_cnt == 3'd4);
    assign m_accept = push & (~m_full | pop);
    assign m_pop    = pop & (m_cnt != 3'd0);
    assign fifo_out = mem[rd_ptr];

    always @(posedge clk) begin
        if (reset) begin
            wr_ptr <= 2'd0;
            rd_ptr <= 2'd0;
            m_cnt  <= 3'd0;
        end else begin
            if (m_accept) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= wr_ptr + 2'd1;
                exp_q.push_back(din[1]);
                exp_q.push_back(din[0]);
            end
            if (m_pop) rd_ptr <= rd_ptr + 2'd1;
            m_cnt <= m_cnt + {2'b00, m_accept} - {2'b00, m_pop};
        end
    end

    fifo_serial_reader #(
        .DEPTH (DEPTH),
        .WIDTH (WIDTH)
    ) dut (
        .i_clk       (clk),
        .i_reset     (reset),
        .i_push      (push),
        .i_full      (m_full),
        .i_fifo_out  (fifo_out),
        .o_pop       (pop),
        .o_ser_out   (ser_out),
        .o_ser_valid (ser_valid),
        .i_ser_ready (ser_ready),
        .o_count     (count),
        .o_empty     (empty),
`ifdef FIFO_READER_CHECK_EN
        .o_sync_err  (sync_err),
`endif
        .o_dbg_state (dbg_state)
    );

    // ---------------- helpers ----------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_word(input logic [1:0] w);
        push = 1'b1;
        din  = w;
        tick();
        push = 1'b0;
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < 60; i++) begin
            if (empty && !ser_valid) break;
            tick();
        end
        check({tag, "_empty"}, {31'd0, empty}, 32'd1);
        check({tag, "_valid"}, {31'd0, ser_valid}, 32'd0);
        check({tag, "_sb_left"}, exp_q.size(), 32'd0);
    endtask

    // ---------------- scoreboard / monitor ----------------
    always @(negedge clk) begin
        if (!reset) begin
            check("count_mirror", {29'd0, count}, {29'd0, m_cnt});
            check("empty_flag", {31'd0, empty}, {31'd0, (m_cnt == 3'd0)});
`ifdef FIFO_READER_CHECK_EN
            check("sync_err", {31'd0, sync_err}, 32'd0);
`endif
            if (ser_valid && ser_ready) begin
                if (exp_q.size() == 0) begin
                    check("sb_underrun", 32'd1, 32'd0);
                end else begin
                    logic [0:0] b;
                    b = exp_q.pop_front();
                    check("ser_bit", {31'd0, ser_out}, {31'd0, b});
                end
            end
        end
    end

    initial begin
        #200000;
        n_fail++;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    // ---------------- directed stimulus ----------------
    initial begin
        reset     = 1'b1;
        push      = 1'b0;
        din       = 2'b00;
        ser_ready = 1'b0;

        // reset
        tick();
        check("rst_count", {29'd0, count}, 32'd0);
        check("rst_empty", {31'd0, empty}, 32'd1);
        check("rst_pop", {31'd0, pop}, 32'd0);
        check("rst_valid", {31'd0, ser_valid}, 32'd0);
        check("rst_ser_out", {31'd0, ser_out}, 32'd0);
        check("rst_state", dbg_state, ST_IDLE);
        reset = 1'b0;
        tick();

        // single word 11, latency and per-bit output
        ser_ready = 1'b1;
        push_word(2'b11);
        check("lat_count", {29'd0, count}, 32'd1);
        check("lat_pop", {31'd0, pop}, 32'd1);
        tick();
        check("lat_valid", {31'd0, ser_valid}, 32'd1);
        check("lat_bit0", {31'd0, ser_out}, 32'd1);
        check("lat_pop_off", {31'd0, pop}, 32'd0);
        tick();
        check("lat_bit1", {31'd0, ser_out}, 32'd1);
        tick();
        check("lat_done_valid", {31'd0, ser_valid}, 32'd0);
        check("lat_done_count", {29'd0, count}, 32'd0);

        // back-to-back pushes with the consumer stalled, then release
        ser_ready = 1'b0;
        push_word(2'b11);
        push = 1'b1; din = 2'b01; tick();
        din = 2'b10; tick();
        din = 2'b01; tick();
        push = 1'b0;
        check("b2b_count", {29'd0, count}, 32'd3);
        check("b2b_state", dbg_state, ST_SHIFT);
        ser_ready = 1'b1;
        for (int k = 0; k < 9; k++) begin
            check("b2b_pop_cadence", {31'd0, pop}, {31'd0, (k % 3 == 2)});
            tick();
        end
        drain("b2b");

        // fill, push while full without pop, push while full with pop
        ser_ready = 1'b0;
        push = 1'b1; din = 2'b10; tick();
        din = 2'b11; tick();
        din = 2'b00; tick();
        din = 2'b01; tick();
        din = 2'b11; tick();
        push = 1'b0;
        check("full_count", {29'd0, count}, 32'd4);
        push_word(2'b10);
        check("full_drop_count", {29'd0, count}, 32'd4);
        ser_ready = 1'b1;
        tick();
        tick();
        check("full_pop", {31'd0, pop}, 32'd1);
        push_word(2'b10);
        check("full_pushpop_count", {29'd0, count}, 32'd4);
        drain("full");

        // stall mid-word
        ser_ready = 1'b0;
        push_word(2'b10);
        push_word(2'b01);
        check("stall_state", dbg_state, ST_SHIFT);
        check("stall_first_bit", {31'd0, ser_out}, 32'd1);
        ser_ready = 1'b1;
        tick();
        ser_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            check("stall_ser_out", {31'd0, ser_out}, 32'd0);
            check("stall_valid", {31'd0, ser_valid}, 32'd1);
            check("stall_no_pop", {31'd0, pop}, 32'd0);
            tick();
        end
        ser_ready = 1'b1;
        drain("stall");

        // reset while shifting
        ser_ready = 1'b0;
        push_word(2'b11);
        push_word(2'b01);
        push_word(2'b10);
        check("mid_state", dbg_state, ST_SHIFT);
        check("mid_count", {29'd0, count}, 32'd2);
        reset = 1'b1;
        tick();
        exp_q.delete();
        check("mid_rst_count", {29'd0, count}, 32'd0);
        check("mid_rst_empty", {31'd0, empty}, 32'd1);
        check("mid_rst_pop", {31'd0, pop}, 32'd0);
        check("mid_rst_valid", {31'd0, ser_valid}, 32'd0);
        check("mid_rst_ser_out", {31'd0, ser_out}, 32'd0);
        check("mid_rst_state", dbg_state, ST_IDLE);
`ifdef FIFO_READER_CHECK_EN
        check("mid_rst_sync_err", {31'd0, sync_err}, 32'd0);
`endif
        reset = 1'b0;
        tick();
        tick();
        check("post_rst_count", {29'd0, count}, 32'd0);
        check("post_rst_state", dbg_state, ST_IDLE);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
